stim_pulse_sequencer: RTL and testbench

//  Parametrised per-channel pulse-train generator that sits between host configuration wires and the
//  per-channel SPI DAC controllers. It turns amplitude/width/period/pulse-count settings into timed DAC

---
 rtl/stim_seq_pkg.sv | 36 +++
 rtl/stim_seq_channel.sv | 186 ++++++++++++++++++
 rtl/stim_pulse_sequencer.sv | 75 +++++++
 tb/tb_stim_pulse_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_seq_pkg.sv
// Shared types and helpers for the stimulation pulse sequencer.
// Optional macro STIM_CHARGE_BALANCE_EN adds the anodic (charge-balance) phase.
package stim_seq_pkg;

    localparam logic [15:0] BASELINE_DEF = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_ANOD  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } ch_state_t;

    // Mirror amp about base (2*base - amp), clamped to [0, 2^code_w-1]
    function automatic logic [31:0] mirror_code(input logic [31:0] base,
                                                input logic [31:0] amp,
                                                input int unsigned code_w);
        logic [33:0] twice;
        logic [33:0] amp_x;
        logic [33:0] diff;
        logic [33:0] max_code;
        twice    = {1'b0, base, 1'b0};
        amp_x    = {2'b00, amp};
        max_code = (34'd1 << code_w) - 34'd1;
        if (amp_x >= twice) begin
            return 32'd0;
        end
        diff = twice - amp_x;
        if (diff > max_code) begin
            return 32'(max_code);
        end
        return 32'(diff);
    endfunction

endpackage

// File: rtl/stim_seq_channel.sv
// One stimulation channel: phase FSM, tick timer, pulse counter and DAC update handshake.
// STIM_CHARGE_BALANCE_EN adds the ANOD phase between PULSE and GAP.
module stim_seq_channel
    import stim_seq_pkg::*;
#(
    parameter int unsigned     CODE_W   = 16,
    parameter int unsigned     TW       = 16,
    parameter logic [CODE_W-1:0] BASELINE = CODE_W'(BASELINE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic              arm,
    input  logic [CODE_W-1:0] cfg_amp,
    input  logic [TW-1:0]     cfg_width,
    input  logic [TW-1:0]     cfg_period,
    input  logic [15:0]       cfg_npulse,
    input  logic              upd_ready,
    output logic              upd_valid,
    output logic [CODE_W-1:0] upd_code,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    ch_state_t         state;
    logic [TW-1:0]     timer;
    logic [15:0]       pcnt;
    logic [CODE_W-1:0] amp_r;
    logic [TW-1:0]     wid_r;
    logic [TW-1:0]     per_r;
    logic [15:0]       np_r;

    logic [TW-1:0]     wid_in;
    logic [TW-1:0]     gap_ld;
    logic              timer_hit;
    logic              last_pulse;
    logic              q_en;
    logic [CODE_W-1:0] q_code;

`ifdef STIM_CHARGE_BALANCE_EN
    localparam int unsigned TW1 = TW + 1;
    logic [TW1-1:0] per_x;
    logic [TW1-1:0] wid_x;
`endif

    // Timer reload values, phase events and the code to queue this cycle
    always_comb begin
        wid_in     = (cfg_width == '0) ? TW'(1) : cfg_width;
        timer_hit  = tick && (timer == '0);
        last_pulse = (np_r != '0) && (16'(pcnt + 16'd1) == np_r);
`ifdef STIM_CHARGE_BALANCE_EN
        per_x  = {1'b0, per_r};
        wid_x  = {wid_r, 1'b0};
        gap_ld = (per_x > wid_x) ? TW'(per_x - wid_x - TW1'(1)) : '0;
`else
        gap_ld = (per_r > wid_r) ? TW'(per_r - wid_r - TW'(1)) : '0;
`endif
        q_en   = 1'b0;
        q_code = BASELINE;
        if (abort) begin
            q_en = (state != ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && arm) begin
                        q_en   = 1'b1;
                        q_code = cfg_amp;
                    end
                end
                ST_PULSE: begin
                    if (timer_hit) begin
                        q_en = 1'b1;
`ifdef STIM_CHARGE_BALANCE_EN
                        q_code = CODE_W'(mirror_code(32'(BASELINE), 32'(amp_r), CODE_W));
`endif
                    end
                end
                ST_ANOD: begin
                    q_en = timer_hit;
                end
                ST_GAP: begin
                    if (timer_hit && !last_pulse) begin
                        q_en   = 1'b1;
                        q_code = amp_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pcnt      <= '0;
            amp_r     <= BASELINE;
            wid_r     <= TW'(1);
            per_r     <= '0;
            np_r      <= '0;
            upd_valid <= 1'b0;
            upd_code  <= BASELINE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (q_en) begin
                upd_code  <= q_code;
                upd_valid <= 1'b1;
                if (upd_valid && !upd_ready) begin
                    overrun <= 1'b1;
                end
            end else if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
            end

            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && arm) begin
                            amp_r <= cfg_amp;
                            wid_r <= wid_in;
                            per_r <= cfg_period;
                            np_r  <= cfg_npulse;
                            pcnt  <= '0;
                            timer <= wid_in - TW'(1);
                            state <= ST_PULSE;
                            busy  <= 1'b1;
                        end
                    end
                    ST_PULSE: begin
                        if (timer_hit) begin
`ifdef STIM_CHARGE_BALANCE_EN
                            state <= ST_ANOD;
                            timer <= wid_r - TW'(1);
`else
                            state <= ST_GAP;
                            timer <= gap_ld;
`endif
                        end else if (tick) begin
                            timer <= timer - TW'(1);
                        end
                    end
`ifdef STIM_CHARGE_BALANCE_EN
                    ST_ANOD: begin
                        if (timer_hit) begin
                            state <= ST_GAP;
                            timer <= gap_ld;
                        end else if (tick) begin
                            timer <= timer - TW'(1);
                        end
                    end
`endif
                    ST_GAP: begin
                        if (timer_hit) begin
                            pcnt <= 16'(pcnt + 16'd1);
                            if (last_pulse) begin
                                state <= ST_FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_PULSE;
                                timer <= wid_r - TW'(1);
                            end
                        end else if (tick) begin
                            timer <= timer - TW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/stim_pulse_sequencer.sv
// Multi-channel pulse-train sequencer: shared tick divider plus NUM_CH channel FSMs.
// Optional macro STIM_CHARGE_BALANCE_EN enables biphasic (anodic) pulses in every channel.
module stim_pulse_sequencer
    import stim_seq_pkg::*;
#(
    parameter int unsigned       NUM_CH   = 12,
    parameter int unsigned       CODE_W   = 16,
    parameter int unsigned       TW       = 16,
    parameter int unsigned       DIV_W    = 8,
    parameter logic [CODE_W-1:0] BASELINE = CODE_W'(BASELINE_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         div_cnt,
    input  logic [NUM_CH-1:0]        arm,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_CH*CODE_W-1:0] cfg_amp,
    input  logic [NUM_CH*TW-1:0]     cfg_width,
    input  logic [NUM_CH*TW-1:0]     cfg_period,
    input  logic [NUM_CH*16-1:0]     cfg_npulse,
    output logic [NUM_CH-1:0]        upd_valid,
    input  logic [NUM_CH-1:0]        upd_ready,
    output logic [NUM_CH*CODE_W-1:0] upd_code,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        overrun
);

    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_lat;
    logic             tick;

    // Tick divider; a new div_cnt is picked up only when the count wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            div_lat  <= div_cnt;
            tick     <= 1'b0;
        end else if (tick_cnt >= div_lat) begin
            tick_cnt <= '0;
            div_lat  <= div_cnt;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            tick     <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stim_seq_channel #(
            .CODE_W   (CODE_W),
            .TW       (TW),
            .BASELINE (BASELINE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .start      (start),
            .abort      (abort),
            .arm        (arm[i]),
            .cfg_amp    (cfg_amp[i*CODE_W +: CODE_W]),
            .cfg_width  (cfg_width[i*TW +: TW]),
            .cfg_period (cfg_period[i*TW +: TW]),
            .cfg_npulse (cfg_npulse[i*16 +: 16]),
            .upd_ready  (upd_ready[i]),
            .upd_valid  (upd_valid[i]),
            .upd_code   (upd_code[i*CODE_W +: CODE_W]),
            .busy       (busy[i]),
            .done       (done[i]),
            .overrun    (overrun[i])
        );
    end

endmodule

// File: tb/tb_stim_pulse_sequencer.sv
// Directed self-checking bench for stim_pulse_sequencer (div_cnt=4: one tick every 5 clocks).
// Define STIM_CHARGE_BALANCE_EN for both RTL and bench to exercise the anodic phase.
module tb_stim_pulse_sequencer;

    localparam int unsigned NCH = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        div_cnt;
    logic [NCH-1:0]    arm;
    logic              start;
    logic              abort;
    logic [NCH*16-1:0] cfg_amp;
    logic [NCH*16-1:0] cfg_width;
    logic [NCH*16-1:0] cfg_period;
    logic [NCH*16-1:0] cfg_npulse;
    logic [NCH-1:0]    upd_valid;
    logic [NCH-1:0]    upd_ready;
    logic [NCH*16-1:0] upd_code;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    stim_pulse_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .div_cnt    (div_cnt),
        .arm        (arm),
        .start      (start),
        .abort      (abort),
        .cfg_amp    (cfg_amp),
        .cfg_width  (cfg_width),
        .cfg_period (cfg_period),
        .cfg_npulse (cfg_npulse),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_code   (upd_code),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] code_of(input int ch);
        return upd_code[ch*16 +: 16];
    endfunction

    task automatic set_cfg(input int ch, input logic [15:0] a, input logic [15:0] w,
                           input logic [15:0] p, input logic [15:0] n);
        cfg_amp[ch*16 +: 16]    = a;
        cfg_width[ch*16 +: 16]  = w;
        cfg_period[ch*16 +: 16] = p;
        cfg_npulse[ch*16 +: 16] = n;
    endtask

    // Arm only channel ch and pulse start for one clock
    task automatic launch(input int ch);
        arm     = '0;
        arm[ch] = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Ticks are acted on at edges where cyc%5==1; leave cyc%5==0 so a launch lands there
    task automatic align();
        while (cyc % 5 != 0) step();
    endtask

    initial begin
        rst        = 1'b1;
        div_cnt    = 8'd4;
        arm        = '0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_amp    = '0;
        cfg_width  = '0;
        cfg_period = '0;
        cfg_npulse = '0;
        upd_ready  = '1;
        run(3);
        check("rst_valid",   32'(upd_valid), 32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_done",    32'(done),      32'h0);
        check("rst_overrun", 32'(overrun),   32'h0);
        check("rst_code0",   32'(code_of(0)),  32'h8000);
        check("rst_code11",  32'(code_of(11)), 32'h8000);
        rst = 1'b0;
        cyc = 0;

        // Finite monophasic train: C000 @0, 8000 @3, C000 @10, 8000 @13, done @20 (ticks)
        set_cfg(0, 16'hC000, 16'd3, 16'd10, 16'd2);
        align();
        launch(0);
        check("t1_code_start",  32'(code_of(0)),  32'hC000);
        check("t1_valid_start", 32'(upd_valid[0]), 32'h1);
        check("t1_busy_start",  32'(busy[0]),      32'h1);
        run(14);
        check("t1_code_14",  32'(code_of(0)),   32'hC000);
        check("t1_valid_14", 32'(upd_valid[0]), 32'h0);
        run(1);
        check("t1_code_15",  32'(code_of(0)),   32'h8000);
        check("t1_valid_15", 32'(upd_valid[0]), 32'h1);
        run(34);
        check("t1_code_49", 32'(code_of(0)), 32'h8000);
        run(1);
        check("t1_code_50", 32'(code_of(0)), 32'hC000);
        check("t1_busy_50", 32'(busy),       32'h001);
        run(15);
        check("t1_code_65", 32'(code_of(0)), 32'h8000);
        run(34);
        check("t1_done_99", 32'(done[0]), 32'h0);
        check("t1_busy_99", 32'(busy[0]), 32'h1);
        run(1);
        check("t1_done_100", 32'(done[0]), 32'h1);
        run(1);
        check("t1_done_101", 32'(done[0]), 32'h0);
        check("t1_busy_101", 32'(busy[0]), 32'h0);
        check("t1_overrun",  32'(overrun), 32'h0);

        // Two codes queued while ready is low: latest shown, overrun sticky
        set_cfg(1, 16'h4000, 16'd1, 16'd3, 16'd1);
        upd_ready = 12'hFFD;
        launch(1);
        check("t2_code_start", 32'(code_of(1)), 32'h4000);
        run(6);
        check("t2_code_latest", 32'(code_of(1)),   32'h8000);
        check("t2_valid_held",  32'(upd_valid[1]), 32'h1);
        check("t2_overrun",     32'(overrun),      32'h002);
        upd_ready = '1;
        run(1);
        check("t2_valid_accept", 32'(upd_valid[1]), 32'h0);
        run(20);
        check("t2_busy_end",     32'(busy[1]),    32'h0);
        check("t2_overrun_held", 32'(overrun[1]), 32'h1);

        // Queue and accept in the same cycle: new code, valid stays, no overrun
        set_cfg(2, 16'h2222, 16'd1, 16'd3, 16'd1);
        while (cyc % 5 != 4) step();
        launch(2);
        check("t3_code_start", 32'(code_of(2)), 32'h2222);
        run(1);
        check("t3_code_next",  32'(code_of(2)),   32'h8000);
        check("t3_valid_next", 32'(upd_valid[2]), 32'h1);
        check("t3_no_overrun", 32'(overrun[2]),   32'h0);
        run(1);
        check("t3_valid_drop", 32'(upd_valid[2]), 32'h0);
        run(20);

        // Continuous train stopped by abort: baseline, idle, no done
        set_cfg(3, 16'h3000, 16'd2, 16'd4, 16'd0);
        launch(3);
        run(35);
        check("t4_busy_running", 32'(busy[3]), 32'h1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_code_abort",  32'(code_of(3)),   32'h8000);
        check("t4_valid_abort", 32'(upd_valid[3]), 32'h1);
        check("t4_busy_abort",  32'(busy[3]),      32'h0);
        check("t4_done_abort",  32'(done),         32'h0);
        run(1);
        check("t4_done_after", 32'(done), 32'h0);
        check("t4_busy_after", 32'(busy), 32'h0);

        // period < width: one-tick gap; start and cfg changes mid-train ignored
        set_cfg(4, 16'h1234, 16'd5, 16'd2, 16'd2);
        align();
        launch(4);
        run(9);
        set_cfg(4, 16'h5555, 16'd1, 16'd2, 16'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_busy_restart", 32'(busy[4]),    32'h1);
        check("t5_code_restart", 32'(code_of(4)), 32'h1234);
        run(14);
        check("t5_code_24", 32'(code_of(4)), 32'h1234);
        run(1);
        check("t5_code_25", 32'(code_of(4)), 32'h8000);
        run(4);
        check("t5_code_29", 32'(code_of(4)), 32'h8000);
        run(1);
        check("t5_code_30", 32'(code_of(4)), 32'h1234);
        run(24);
        check("t5_code_54", 32'(code_of(4)), 32'h1234);
        run(1);
        check("t5_code_55", 32'(code_of(4)), 32'h8000);
        run(4);
        check("t5_done_59", 32'(done[4]), 32'h0);
        run(1);
        check("t5_done_60", 32'(done[4]), 32'h1);
        run(2);

        // abort and start together on an idle armed channel
        set_cfg(5, 16'h6666, 16'd2, 16'd4, 16'd1);
        arm      = '0;
        arm[5]   = 1'b1;
        start    = 1'b1;
        abort    = 1'b1;
        step();
        start    = 1'b0;
        abort    = 1'b0;
        check("t6_busy",  32'(busy[5]),      32'h0);
        check("t6_valid", 32'(upd_valid[5]), 32'h0);
        check("t6_code",  32'(code_of(5)),   32'h8000);

        // Reset mid-pulse returns every output to its reset value
        set_cfg(6, 16'h7777, 16'd10, 16'd20, 16'd1);
        launch(6);
        run(3);
        check("t7_busy_pre", 32'(busy[6]),    32'h1);
        check("t7_code_pre", 32'(code_of(6)), 32'h7777);
        rst = 1'b1;
        step();
        check("t7_code_rst",    32'(code_of(6)), 32'h8000);
        check("t7_valid_rst",   32'(upd_valid),  32'h0);
        check("t7_busy_rst",    32'(busy),       32'h0);
        check("t7_overrun_rst", 32'(overrun),    32'h0);
        step();
        rst = 1'b0;
        cyc = 0;

`ifdef STIM_CHARGE_BALANCE_EN
        // Biphasic: A000 @0, 6000 @2, 8000 @4, done @10 (ticks)
        set_cfg(7, 16'hA000, 16'd2, 16'd10, 16'd1);
        align();
        launch(7);
        check("t8_code_0", 32'(code_of(7)), 32'hA000);
        run(9);
        check("t8_code_9", 32'(code_of(7)), 32'hA000);
        run(1);
        check("t8_code_10", 32'(code_of(7)), 32'h6000);
        run(9);
        check("t8_code_19", 32'(code_of(7)), 32'h6000);
        run(1);
        check("t8_code_20", 32'(code_of(7)), 32'h8000);
        run(29);
        check("t8_done_49", 32'(done[7]), 32'h0);
        run(1);
        check("t8_done_50", 32'(done[7]), 32'h1);
        run(2);

        // Zero amplitude: mirrored code saturates at full scale
        set_cfg(8, 16'h0000, 16'd1, 16'd4, 16'd1);
        align();
        launch(8);
        run(4);
        check("t9_code_4", 32'(code_of(8)), 32'h0000);
        run(1);
        check("t9_code_sat", 32'(code_of(8)), 32'hFFFF);
        run(5);
        check("t9_code_base", 32'(code_of(8)), 32'h8000);
        run(20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
